// File: rtl/dsp_nco.sv
// rtl/dsp_nco.sv - multi-channel time-multiplexed NCO sharing one quarter-wave sine table
module dsp_nco #(
    parameter int NUM_CH      = 4,
    parameter int PHASE_WIDTH = 32,
    parameter int ADDR_WIDTH  = 12,
    parameter int DATA_WIDTH  = 12
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         cfg_we,
    input  logic [(NUM_CH > 1 ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
    input  logic [PHASE_WIDTH-1:0]                       cfg_fcw,
    input  logic [PHASE_WIDTH-1:0]                       cfg_poff,
    input  logic                                         sync,
    input  logic                                         tick,
    output logic                                         out_valid,
    output logic [(NUM_CH > 1 ? $clog2(NUM_CH) : 1)-1:0] out_ch,
    output logic signed [DATA_WIDTH-1:0]                 out_sin,
    output logic signed [DATA_WIDTH-1:0]                 out_cos,
    output logic                                         overrun
);

    localparam int CW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int TW  = ADDR_WIDTH - 2;
    localparam int QTR = 1 << TW;
    localparam logic [CW-1:0] LAST     = CW'(NUM_CH - 1);
    localparam logic [CW:0]   NUM_CH_L = (CW + 1)'(NUM_CH);

    // Entry k-1 = round(A*sin(pi/2*k/QTR)), evaluated in Q28 fixed point at elaboration.
    function automatic logic [DATA_WIDTH-1:0] sine_entry(input int k);
        longint x, x2, term, sum, amp, val;
        amp  = (longint'(1) << (DATA_WIDTH - 1)) - 1;
        x    = (longint'(421657428) * longint'(k)) / longint'(QTR);
        x2   = (x * x) >>> 28;
        term = x;
        sum  = x;
        for (int n = 1; n <= 9; n++) begin
            term = -((term * x2) >>> 28) / longint'((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        val = (sum * amp + (longint'(1) << 27)) >>> 28;
        if (val > amp) val = amp;
        if (val < 0) val = 0;
        return val[DATA_WIDTH-1:0];
    endfunction

    logic [DATA_WIDTH-1:0] sin_tbl [QTR];
    for (genvar k = 0; k < QTR; k++) begin : g_tbl
        localparam logic [DATA_WIDTH-1:0] ENTRY = sine_entry(k + 1);
        assign sin_tbl[k] = ENTRY;
    end

    typedef enum logic {IDLE, RUN} state_t;
    state_t state;
    logic [CW-1:0] slot;

    logic [PHASE_WIDTH-1:0] acc  [NUM_CH];
    logic [PHASE_WIDTH-1:0] fcw  [NUM_CH];
    logic [PHASE_WIDTH-1:0] poff [NUM_CH];

    logic [PHASE_WIDTH-1:0] acc_cur;
    logic [PHASE_WIDTH-1:0] phase_sum;

    logic                  v1, v2, v3;
    logic [CW-1:0]         ch1, ch2, ch3;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [1:0]            q2, q3;
    logic                  zero2;
    logic [TW-1:0]         ia2, ib2, r1;
    logic [DATA_WIDTH-1:0] sa3, sb3;

    // A sync landing in a channel's own slot makes that slot see a cleared accumulator.
    always_comb begin
        acc_cur   = sync ? '0 : acc[slot];
        phase_sum = acc_cur + poff[slot];
    end

    if (PHASE_WIDTH > ADDR_WIDTH) begin : g_lsb
        logic unused_phase_lsbs;
        assign unused_phase_lsbs = ^phase_sum[PHASE_WIDTH-ADDR_WIDTH-1:0];
    end

    assign r1 = addr1[TW-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            slot    <= '0;
            overrun <= 1'b0;
            v1      <= 1'b0;
            ch1     <= '0;
            addr1   <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                acc[i]  <= '0;
                fcw[i]  <= '0;
                poff[i] <= '0;
            end
        end else begin
            if (cfg_we && ({1'b0, cfg_ch} < NUM_CH_L)) begin
                fcw[cfg_ch]  <= cfg_fcw;
                poff[cfg_ch] <= cfg_poff;
            end
            if (sync) begin
                for (int i = 0; i < NUM_CH; i++) acc[i] <= '0;
            end
            v1 <= (state == RUN);
            if (state == RUN) begin
                ch1        <= slot;
                addr1      <= phase_sum[PHASE_WIDTH-1 -: ADDR_WIDTH];
                acc[slot]  <= acc_cur + fcw[slot];
            end
            case (state)
                IDLE: begin
                    if (tick) begin
                        state <= RUN;
                        slot  <= '0;
                    end
                end
                RUN: begin
                    // The final-slot cycle may accept the next tick seamlessly.
                    if (slot == LAST) begin
                        if (tick) slot <= '0;
                        else      state <= IDLE;
                    end else begin
                        slot <= slot + 1'b1;
                        if (tick) overrun <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v2        <= 1'b0;
            v3        <= 1'b0;
            ch2       <= '0;
            ch3       <= '0;
            q2        <= '0;
            q3        <= '0;
            zero2     <= 1'b0;
            ia2       <= '0;
            ib2       <= '0;
            sa3       <= '0;
            sb3       <= '0;
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_sin   <= '0;
            out_cos   <= '0;
        end else begin
            // S(r) reads entry r-1 (zero when r=0); S(QTR-r) reads entry ~r.
            v2    <= v1;
            ch2   <= ch1;
            q2    <= addr1[ADDR_WIDTH-1 -: 2];
            zero2 <= (r1 == '0);
            ia2   <= r1 - 1'b1;
            ib2   <= ~r1;

            v3  <= v2;
            ch3 <= ch2;
            q3  <= q2;
            sa3 <= zero2 ? '0 : sin_tbl[ia2];
            sb3 <= sin_tbl[ib2];

            out_valid <= v3;
            if (v3) begin
                out_ch <= ch3;
                case (q3)
                    2'd0: begin out_sin <= sa3;  out_cos <= sb3;  end
                    2'd1: begin out_sin <= sb3;  out_cos <= -sa3; end
                    2'd2: begin out_sin <= -sa3; out_cos <= -sb3; end
                    default: begin out_sin <= -sb3; out_cos <= sa3; end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dsp_nco.sv
// tb/tb_dsp_nco.sv - scoreboard bench for dsp_nco (4-channel and 1-channel instances)
module tb_dsp_nco;

    logic clk;
    logic rst;
    int   cyc;
    int   vectors;
    int   miscompares;

    logic        cfg_we, sync, tick;
    logic [1:0]  cfg_ch;
    logic [31:0] cfg_fcw, cfg_poff;
    logic        o_valid, o_ovr;
    logic [1:0]  o_ch;
    logic [11:0] o_sin, o_cos;

    logic        cfg1_we, sync1, tick1;
    logic [0:0]  cfg1_ch;
    logic [31:0] cfg1_fcw, cfg1_poff;
    logic        o1_valid, o1_ovr;
    logic [0:0]  o1_ch;
    logic [11:0] o1_sin, o1_cos;

    typedef struct {
        int          ch;
        logic [11:0] s;
        logic [11:0] c;
        int          cyc;
    } exp_t;

    exp_t q4[$];
    exp_t q1[$];

    logic [31:0] m_acc [4];
    logic [31:0] m_fcw [4];
    logic [31:0] m_poff[4];
    logic [31:0] m1_acc;

    dsp_nco #(.NUM_CH(4), .PHASE_WIDTH(32), .ADDR_WIDTH(12), .DATA_WIDTH(12)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_fcw(cfg_fcw),
        .cfg_poff(cfg_poff), .sync(sync), .tick(tick), .out_valid(o_valid),
        .out_ch(o_ch), .out_sin(o_sin), .out_cos(o_cos), .overrun(o_ovr)
    );

    dsp_nco #(.NUM_CH(1), .PHASE_WIDTH(32), .ADDR_WIDTH(12), .DATA_WIDTH(12)) dut1 (
        .clk(clk), .rst(rst), .cfg_we(cfg1_we), .cfg_ch(cfg1_ch), .cfg_fcw(cfg1_fcw),
        .cfg_poff(cfg1_poff), .sync(sync1), .tick(tick1), .out_valid(o1_valid),
        .out_ch(o1_ch), .out_sin(o1_sin), .out_cos(o1_cos), .overrun(o1_ovr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Hand-computed {sin, cos} for every phase the stimulus can reach (A=2047).
    function automatic logic [23:0] lut(input logic [31:0] ph);
        case (ph)
            32'h0000_0000, 32'h000F_FFFF: lut = 24'h000_7FF;
            32'h0010_0000: lut = 24'h003_7FF;
            32'hFFF0_0000: lut = 24'hFFD_7FF;
            32'h2000_0000: lut = 24'h5A7_5A7;
            32'h4000_0000: lut = 24'h7FF_000;
            32'h6000_0000: lut = 24'h5A7_A59;
            32'h8000_0000: lut = 24'h000_801;
            32'hA000_0000: lut = 24'hA59_A59;
            32'hC000_0000: lut = 24'h801_000;
            32'hE000_0000: lut = 24'hA59_5A7;
            default:       lut = 24'hxxx_xxx;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic cfg(input int ch, input logic [31:0] f, input logic [31:0] p);
        cfg_we   = 1'b1;
        cfg_ch   = ch[1:0];
        cfg_fcw  = f;
        cfg_poff = p;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        m_fcw[ch]  = f;
        m_poff[ch] = p;
    endtask

    // sync_at: channel whose slot coincides with sync (0 = with the tick), -1 none.
    task automatic do_tick(input int sync_at, input int hold);
        logic [31:0] ph;
        logic [23:0] sc;
        int n;
        n = cyc;
        for (int c = 0; c < 4; c++) begin
            if (c == sync_at) begin
                for (int i = 0; i < 4; i++) m_acc[i] = '0;
            end
            ph       = m_acc[c] + m_poff[c];
            m_acc[c] = m_acc[c] + m_fcw[c];
            sc       = lut(ph);
            q4.push_back('{c, sc[23:12], sc[11:0], n + 5 + c});
        end
        tick = 1'b1;
        if (sync_at == 0) sync = 1'b1;
        repeat (hold) begin @(posedge clk); #1; end
        tick = 1'b0;
        sync = 1'b0;
        if (sync_at > 0) begin
            repeat (sync_at) begin @(posedge clk); #1; end
            sync = 1'b1;
            @(posedge clk); #1;
            sync = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((q4.size() != 0 || q1.size() != 0) && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        idle(2);
    endtask

    initial begin : mon4
        exp_t e;
        forever begin
            @(negedge clk);
            if (o_valid) begin
                vectors++;
                if (q4.size() == 0) begin
                    miscompares++;
                    $display("FAIL dut4_unexpected ch=%0d sin=%h cos=%h cyc=%0d", o_ch, o_sin, o_cos, cyc);
                end else begin
                    e = q4.pop_front();
                    if (int'(o_ch) != e.ch || o_sin !== e.s || o_cos !== e.c || cyc != e.cyc) begin
                        miscompares++;
                        $display("FAIL dut4_sample got ch=%0d sin=%h cos=%h cyc=%0d exp ch=%0d sin=%h cos=%h cyc=%0d",
                                 o_ch, o_sin, o_cos, cyc, e.ch, e.s, e.c, e.cyc);
                    end
                end
            end
        end
    end

    initial begin : mon1
        exp_t e;
        forever begin
            @(negedge clk);
            if (o1_valid) begin
                vectors++;
                if (q1.size() == 0) begin
                    miscompares++;
                    $display("FAIL dut1_unexpected sin=%h cos=%h cyc=%0d", o1_sin, o1_cos, cyc);
                end else begin
                    e = q1.pop_front();
                    if (int'(o1_ch) != e.ch || o1_sin !== e.s || o1_cos !== e.c || cyc != e.cyc) begin
                        miscompares++;
                        $display("FAIL dut1_sample got ch=%0d sin=%h cos=%h cyc=%0d exp ch=%0d sin=%h cos=%h cyc=%0d",
                                 o1_ch, o1_sin, o1_cos, cyc, e.ch, e.s, e.c, e.cyc);
                    end
                end
            end
        end
    end

    initial begin
        int nv;
        logic [23:0] sc;
        int n;
        cyc = 0; vectors = 0; miscompares = 0;
        rst = 1'b1;
        cfg_we = 1'b0; cfg_ch = '0; cfg_fcw = '0; cfg_poff = '0; sync = 1'b0; tick = 1'b0;
        cfg1_we = 1'b0; cfg1_ch = '0; cfg1_fcw = '0; cfg1_poff = '0; sync1 = 1'b0; tick1 = 1'b0;
        for (int i = 0; i < 4; i++) begin m_acc[i] = '0; m_fcw[i] = '0; m_poff[i] = '0; end
        m1_acc = '0;
        idle(3);
        rst = 1'b0;
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_ch", 32'(o_ch), 32'd0);
        chk("rst_sin", 32'(o_sin), 32'd0);
        chk("rst_cos", 32'(o_cos), 32'd0);
        chk("rst_overrun", 32'(o_ovr), 32'd0);
        chk("rst1_valid", 32'(o1_valid), 32'd0);
        chk("rst1_overrun", 32'(o1_ovr), 32'd0);

        // Static offsets, fcw = 0: lookup boundaries and truncation.
        cfg(0, 32'h0, 32'h0000_0000);
        cfg(1, 32'h0, 32'h2000_0000);
        cfg(2, 32'h0, 32'h4000_0000);
        cfg(3, 32'h0, 32'hFFF0_0000);
        do_tick(-1, 1); idle(6);
        cfg(0, 32'h0, 32'h000F_FFFF);
        cfg(1, 32'h0, 32'h0010_0000);
        cfg(2, 32'h0, 32'h8000_0000);
        cfg(3, 32'h0, 32'hC000_0000);
        do_tick(-1, 1); idle(6);

        // Running channels: +quarter, -quarter (wrap), static quarter, eighth steps.
        cfg(0, 32'h4000_0000, 32'h0);
        cfg(1, 32'hC000_0000, 32'h0);
        cfg(2, 32'h0000_0000, 32'h4000_0000);
        cfg(3, 32'h2000_0000, 32'h2000_0000);
        for (int k = 0; k < 4; k++) begin do_tick(-1, 1); idle(6); end

        // Config write landing in ch1's own slot: old values used for that slot.
        do_tick(-1, 1);
        @(posedge clk); #1;
        cfg(1, 32'h4000_0000, 32'h6000_0000);
        idle(6);
        do_tick(-1, 1); idle(6);

        do_tick(2, 1); idle(6);

        chk("overrun_clear", 32'(o_ovr), 32'd0);
        do_tick(-1, 2); idle(6);
        chk("overrun_set", 32'(o_ovr), 32'd1);
        do_tick(-1, 1); idle(6);
        chk("overrun_sticky", 32'(o_ovr), 32'd1);

        do_tick(0, 1); idle(6);
        drain();
        chk("q4_drained", 32'(q4.size()), 32'd0);

        // Reset mid-sweep: nothing from the interrupted sweep may appear.
        tick = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        chk("midrst_valid", 32'(o_valid), 32'd0);
        chk("midrst_sin", 32'(o_sin), 32'd0);
        chk("midrst_cos", 32'(o_cos), 32'd0);
        chk("midrst_overrun", 32'(o_ovr), 32'd0);
        nv = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (o_valid) nv++;
        end
        chk("midrst_no_valid", 32'(nv), 32'd0);
        for (int i = 0; i < 4; i++) begin m_acc[i] = '0; m_fcw[i] = '0; m_poff[i] = '0; end
        do_tick(-1, 1); idle(6);

        // Single channel: quarter steps every 4 cycles, then back-to-back ticks.
        cfg1_we = 1'b1; cfg1_fcw = 32'h4000_0000; cfg1_poff = 32'h0;
        @(posedge clk); #1;
        cfg1_we = 1'b0;
        for (int k = 0; k < 8; k++) begin
            n  = cyc;
            sc = lut(m1_acc);
            m1_acc = m1_acc + 32'h4000_0000;
            q1.push_back('{0, sc[23:12], sc[11:0], n + 5});
            tick1 = 1'b1;
            @(posedge clk); #1;
            if (k < 4) begin
                tick1 = 1'b0;
                idle(3);
            end
        end
        tick1 = 1'b0;
        drain();
        chk("dut1_no_overrun", 32'(o1_ovr), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);
        chk("q4_final", 32'(q4.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
